// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-port sharing logic.
//   - arb_state_e : arbiter sequencing states
//   - REQ_IF/REQ_D: requester identifiers (fetch = 0, data = 1)
//   - DEF_ADDR_W/DEF_DATA_W: default bus widths
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } arb_state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter (purely combinational).
// Ports:
//   en_i   : arbitration enabled; grant is all-zero when low
//   req_i  : requests, bit 0 = fetch (REQ_IF), bit 1 = data (REQ_D)
//   last_i : requester served most recently
//   gnt_o  : one-hot grant, same bit order as req_i
module rr_arb2
  import cpu_mem_pkg::*;
(
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        // Tie: the requester that was not served last goes first.
        2'b11:   gnt_o = (last_i == REQ_D) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and data access.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   if_req/if_addr                  : fetch request (level) and address
//   if_gnt/if_done/if_rdata         : fetch in progress, completion pulse, data
//   d_req/d_we/d_addr/d_wdata       : data request, store flag, address, data
//   d_gnt/d_done/d_rdata            : data in progress, completion pulse, data
//   mem_addr/mem_wdata              : memory address and write data
//   mem_read/mem_write              : memory strobes (held during ACCESS)
//   mem_rdata/mem_ready             : memory read data and completion
//   timeout_err                     : marks the current done pulse as aborted
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              winner_q, winner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [1:0]        gnt;

  // Arbitration only looks at requests while idle; requests at any other
  // time (including a drop mid-access) have no effect.
  rr_arb2 u_arb (
    .en_i  (state_q == ST_IDLE),
    .req_i ({d_req, if_req}),
    .last_i(last_q),
    .gnt_o (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= REQ_D;   // makes fetch win the first tie
      winner_q   <= REQ_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      winner_q   <= winner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    winner_d   = winner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt[0]) begin
          winner_d   = REQ_IF;
          last_d     = REQ_IF;
          addr_d     = if_addr;
          wdata_d    = '0;
          we_d       = 1'b0;
          wait_cnt_d = '0;
          state_d    = ST_ACCESS;
        end else if (gnt[1]) begin
          winner_d   = REQ_D;
          last_d     = REQ_D;
          addr_d     = d_addr;
          wdata_d    = d_wdata;
          we_d       = d_we;
          wait_cnt_d = '0;
          state_d    = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (mem_ready) begin
          // Read data is captured here so it is already valid during DONE.
          if (!we_q) begin
            if (winner_q == REQ_IF) if_rdata_d = mem_rdata;
            else                    d_rdata_d  = mem_rdata;
          end
          state_d = ST_DONE;
        end else if (wait_cnt_q == CNT_LAST) begin
          // Aborted access reports zero data alongside timeout_err.
          if (winner_q == REQ_IF) if_rdata_d = '0;
          else                    d_rdata_d  = '0;
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode only from registered state, so no input reaches an
  // output combinationally.
  logic in_access, in_finish;
  assign in_access = (state_q == ST_ACCESS);
  assign in_finish = (state_q == ST_DONE) || (state_q == ST_ERR);

  assign if_gnt      = in_access && (winner_q == REQ_IF);
  assign d_gnt       = in_access && (winner_q == REQ_D);
  assign if_done     = in_finish && (winner_q == REQ_IF);
  assign d_done      = in_finish && (winner_q == REQ_D);
  assign timeout_err = (state_q == ST_ERR);
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_read    = in_access && !we_q;
  assign mem_write   = in_access && we_q;

endmodule
